// File: rtl/intersection_phase_arbiter_pkg.sv
// Shared types and constants for the four-approach intersection phase arbiter.
package intersection_phase_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GREEN  = 2'd1,
    YELLOW = 2'd2,
    ALLRED = 2'd3
  } phase_t;

  localparam logic [1:0] DIR_N = 2'd0;
  localparam logic [1:0] DIR_E = 2'd1;
  localparam logic [1:0] DIR_S = 2'd2;
  localparam logic [1:0] DIR_W = 2'd3;

  localparam int GREEN_MIN_DEF = 4;
  localparam int GREEN_MAX_DEF = 12;
  localparam int YELLOW_T_DEF  = 3;
  localparam int ALLRED_T_DEF  = 2;

endpackage

// File: rtl/intersection_phase_arbiter_rr_pick4.sv
// Round-robin picker: first requesting index after 'last', wrapping back to 'last' itself.
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic [1:0] pick,
  output logic       any
);

  logic [1:0] cand;

  always_comb begin
    pick = last;
    cand = last;
    // Scan farthest offset first so the nearest requester overwrites it.
    for (int k = 4; k >= 1; k--) begin
      cand = last + 2'(k);
      if (req[cand]) pick = cand;
    end
    any = |req;
  end

endmodule

// File: rtl/intersection_phase_arbiter.sv
// Four-approach signal controller: round-robin green phases with min/max green,
// fixed yellow and all-red clearance, and emergency preemption.
module intersection_phase_arbiter
  import intersection_phase_arbiter_pkg::*;
#(
  parameter int GREEN_MIN = GREEN_MIN_DEF,
  parameter int GREEN_MAX = GREEN_MAX_DEF,
  parameter int YELLOW_T  = YELLOW_T_DEF,
  parameter int ALLRED_T  = ALLRED_T_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       N,
  input  logic       E,
  input  logic       S,
  input  logic       W,
  input  logic       emg_valid,
  input  logic [1:0] emg_dir,
  output logic       Rn, Yn, Gn,
  output logic       Re, Ye, Ge,
  output logic       Rs, Ys, Gs,
  output logic       Rw, Yw, Gw,
  output logic [1:0] grant_dir,
  output logic       grant_valid
);

  if (GREEN_MIN < 1)         begin : g_bad_min    $error("GREEN_MIN must be >= 1"); end
  if (GREEN_MAX < GREEN_MIN) begin : g_bad_max    $error("GREEN_MAX must be >= GREEN_MIN"); end
  if (YELLOW_T < 1)          begin : g_bad_yellow $error("YELLOW_T must be >= 1"); end
  if (ALLRED_T < 1)          begin : g_bad_allred $error("ALLRED_T must be >= 1"); end
  // The one saturating timer also measures yellow and all-red, so it must reach their last count.
  if (YELLOW_T > GREEN_MAX + 1 || ALLRED_T > GREEN_MAX + 1) begin : g_bad_timer
    $error("YELLOW_T and ALLRED_T must not exceed GREEN_MAX+1");
  end

  localparam int TW = $clog2(GREEN_MAX + 1);
  localparam logic [TW-1:0] MIN_LAST = TW'(GREEN_MIN - 1);
  localparam logic [TW-1:0] MAX_LAST = TW'(GREEN_MAX - 1);
  localparam logic [TW-1:0] T_SAT    = TW'(GREEN_MAX);
  localparam logic [TW-1:0] Y_LAST   = TW'(YELLOW_T - 1);
  localparam logic [TW-1:0] A_LAST   = TW'(ALLRED_T - 1);

  phase_t          state, state_n;
  logic [TW-1:0]   timer, timer_n;
  logic [1:0]      last_served, last_n, grant_n;
  logic [3:0]      req, sel_n;
  logic [3:0]      lamp_r, lamp_y, lamp_g;
  logic            own, others, gv_n;
  logic [1:0]      pick;
  logic            any;

  assign req = {W, S, E, N};

  rr_pick4 u_rr (
    .req  (req),
    .last (last_served),
    .pick (pick),
    .any  (any)
  );

  always_comb begin
    own     = req[grant_dir];
    others  = |(req & ~(4'b0001 << grant_dir));
    state_n = state;
    grant_n = grant_dir;
    last_n  = last_served;

    unique case (state)
      IDLE, ALLRED: begin
        if (state == IDLE || timer == A_LAST) begin
          if (emg_valid) begin
            state_n = GREEN;
            grant_n = emg_dir;
            last_n  = emg_dir;
          end else if (any) begin
            state_n = GREEN;
            grant_n = pick;
            last_n  = pick;
          end else begin
            state_n = IDLE;
          end
        end
      end
      GREEN: begin
        // Preemption overrides both the minimum and maximum green limits.
        if (emg_valid) begin
          if (emg_dir != grant_dir) state_n = YELLOW;
        end else if (timer >= MIN_LAST && !own) begin
          state_n = YELLOW;
        end else if (timer >= MAX_LAST && own && others) begin
          state_n = YELLOW;
        end
      end
      YELLOW: begin
        if (timer == Y_LAST) state_n = ALLRED;
      end
    endcase

    if (state_n != state)  timer_n = '0;
    else if (timer != T_SAT) timer_n = timer + 1'b1;
    else                   timer_n = timer;

    sel_n = 4'b0001 << grant_n;
    gv_n  = (state_n == GREEN) || (state_n == YELLOW);
  end

  // State register stage: lamps decoded from next state so outputs are registered.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      timer       <= '0;
      last_served <= DIR_W;
      grant_dir   <= DIR_N;
      grant_valid <= 1'b0;
      lamp_r      <= 4'hF;
      lamp_y      <= 4'h0;
      lamp_g      <= 4'h0;
    end else begin
      state       <= state_n;
      timer       <= timer_n;
      last_served <= last_n;
      grant_dir   <= grant_n;
      grant_valid <= gv_n;
      lamp_g      <= (state_n == GREEN)  ? sel_n : 4'h0;
      lamp_y      <= (state_n == YELLOW) ? sel_n : 4'h0;
      lamp_r      <= gv_n ? ~sel_n : 4'hF;
    end
  end

  assign {Rw, Rs, Re, Rn} = lamp_r;
  assign {Yw, Ys, Ye, Yn} = lamp_y;
  assign {Gw, Gs, Ge, Gn} = lamp_g;

endmodule

// File: tb/tb_intersection_phase_arbiter.sv
// Directed scoreboard bench for intersection_phase_arbiter with default timing.
module tb_intersection_phase_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       N, E, S, W;
  logic       emg_valid;
  logic [1:0] emg_dir;
  logic       Rn, Yn, Gn, Re, Ye, Ge, Rs, Ys, Gs, Rw, Yw, Gw;
  logic [1:0] grant_dir;
  logic       grant_valid;

  intersection_phase_arbiter dut (
    .clk(clk), .reset(reset),
    .N(N), .E(E), .S(S), .W(W),
    .emg_valid(emg_valid), .emg_dir(emg_dir),
    .Rn(Rn), .Yn(Yn), .Gn(Gn),
    .Re(Re), .Ye(Ye), .Ge(Ge),
    .Rs(Rs), .Ys(Ys), .Gs(Gs),
    .Rw(Rw), .Yw(Yw), .Gw(Gw),
    .grant_dir(grant_dir), .grant_valid(grant_valid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] y;
    logic [3:0] g;
    logic       gv;
    logic [1:0] gd;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   step = 0;

  localparam int K_RED = 0, K_GRN = 1, K_YEL = 2;

  task automatic push(input int kind, input int d, input int n);
    exp_t e;
    e.r = 4'hF; e.y = 4'h0; e.g = 4'h0; e.gv = 1'b0; e.gd = 2'(d);
    if (kind == K_GRN) begin e.g[d] = 1'b1; e.r[d] = 1'b0; e.gv = 1'b1; end
    if (kind == K_YEL) begin e.y[d] = 1'b1; e.r[d] = 1'b0; e.gv = 1'b1; end
    repeat (n) sb.push_back(e);
  endtask

  task automatic tick();
    exp_t        e;
    logic [11:0] obs, want;
    @(posedge clk); #1;
    step++;
    obs = {Rw, Rs, Re, Rn, Yw, Ys, Ye, Yn, Gw, Gs, Ge, Gn};
    if (sb.size() == 0) begin
      vectors++; miscompares++;
      $display("FAIL sb_empty step %0d: got output with no expectation queued", step);
    end else begin
      e = sb.pop_front();
      want = {e.r, e.y, e.g};
      vectors++;
      assert (obs === want) else begin
        miscompares++;
        $error("FAIL lamps step %0d: got RYG=%b want %b", step, obs, want);
      end
      vectors++;
      assert (grant_valid === e.gv) else begin
        miscompares++;
        $error("FAIL grant_valid step %0d: got %b want %b", step, grant_valid, e.gv);
      end
      if (e.gv) begin
        vectors++;
        assert (grant_dir === e.gd) else begin
          miscompares++;
          $error("FAIL grant_dir step %0d: got %0d want %0d", step, grant_dir, e.gd);
        end
      end
    end
  endtask

  task automatic drain();
    while (sb.size() > 0) tick();
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0; N = 0; E = 0; S = 0; W = 0; emg_valid = 0; emg_dir = 2'd0;
    push(K_RED, 0, n);
    drain();
    vectors++;
    assert (grant_dir === 2'd0) else begin
      miscompares++;
      $error("FAIL reset_grant_dir step %0d: got %0d want 0", step, grant_dir);
    end
    reset = 1'b1;
  endtask

  initial begin
    // Power-on reset, then a quiet intersection stays all red.
    do_reset(2);
    push(K_RED, 0, 6);
    drain();

    // Single-cycle N request: minimum green, yellow, clearance, back to idle.
    N = 1;
    push(K_GRN, 0, 4); push(K_YEL, 0, 3); push(K_RED, 0, 2); push(K_RED, 0, 2);
    tick();
    N = 0;
    drain();

    // N and E contend: each gets the maximum green.
    do_reset(1);
    N = 1; E = 1;
    push(K_GRN, 0, 12); push(K_YEL, 0, 3); push(K_RED, 0, 2);
    push(K_GRN, 1, 12); push(K_YEL, 1, 3); push(K_RED, 0, 2);
    push(K_GRN, 0, 1);
    drain();

    // All four contend: full rotation N, E, S, W, N.
    do_reset(1);
    N = 1; E = 1; S = 1; W = 1;
    for (int d = 0; d < 4; d++) begin
      push(K_GRN, d, 12); push(K_YEL, d, 3); push(K_RED, 0, 2);
    end
    push(K_GRN, 0, 1);
    drain();

    // Preemption to S during N green, held beyond GREEN_MAX, then W next.
    do_reset(1);
    N = 1;
    push(K_GRN, 0, 2);
    drain();
    emg_valid = 1; emg_dir = 2'd2;
    push(K_YEL, 0, 3); push(K_RED, 0, 2); push(K_GRN, 2, 16);
    drain();
    emg_valid = 0; W = 1;
    push(K_YEL, 2, 3); push(K_RED, 0, 2); push(K_GRN, 3, 3);
    drain();

    // Reset during the second yellow cycle goes straight to all red.
    do_reset(2);
    N = 1;
    push(K_GRN, 0, 4); push(K_YEL, 0, 2);
    tick();
    N = 0;
    drain();
    reset = 1'b0; N = 1; W = 1;
    push(K_RED, 0, 1);
    drain();
    reset = 1'b1;
    push(K_GRN, 0, 1);
    drain();

    vectors++;
    assert (sb.size() == 0) else begin
      miscompares++;
      $error("FAIL sb_leftover: got %0d entries want 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
